branch_resolve_unit: RTL

Pipelined, parametrised branch/jump resolution unit for the execute stage. Evaluates B-type conditions and JAL/JALR targets on XLEN-wide operands, compares the outcome with the fetch-stage prediction, and raises a redirect on mispredict. Keeps a table of 2-bit saturating counters (BHT) that fetch reads combinationally and that is trained by resolved conditional branches.

---
 rtl/branch_resolve_unit_pkg.sv | 41 ++++
 rtl/branch_history_table.sv | 30 +++
 rtl/branch_resolve_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for branch resolution: instruction classes,
// branch funct3 encodings, BHT counter type and decode helpers.
package branch_resolve_unit_pkg;

  typedef enum logic [2:0] {
    R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE
  } instruction_op_type;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] OPC_JALR = 7'b1100111;

  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t BHT_INIT = 2'b01;

  typedef enum logic [1:0] {K_NONE, K_BRANCH, K_JAL, K_JALR} br_kind_e;

  // Only I_TYPE needs the opcode: it is a jump solely when it carries JALR.
  function automatic br_kind_e decode_kind(instruction_op_type optype, logic [6:0] opcode);
    br_kind_e k;
    k = K_NONE;
    if (optype == B_TYPE) k = K_BRANCH;
    else if (optype == J_TYPE) k = K_JAL;
    else if (optype == I_TYPE && opcode == OPC_JALR) k = K_JALR;
    return k;
  endfunction

  function automatic bht_ctr_t bht_next(bht_ctr_t c, logic taken);
    bht_ctr_t n;
    n = c;
    if (taken && c != 2'b11) n = c + 2'b01;
    else if (!taken && c != 2'b00) n = c - 2'b01;
    return n;
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// Table of 2-bit saturating direction counters with one combinational read
// port and one update port; a same-cycle read sees the pre-update value.
module branch_history_table
  import branch_resolve_unit_pkg::*;
#(
  parameter int ENTRIES = 64,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output bht_ctr_t         rd_ctr_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  bht_ctr_t ctr_q [ENTRIES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BHT_INIT;
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= bht_next(ctr_q[upd_idx_i], upd_taken_i);
    end
  end

  assign rd_ctr_o = ctr_q[rd_idx_i];

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch/jump resolution: S1 captures compare flags and candidate
// targets, S2 holds the resolved outcome and trains the BHT on delivery.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  instruction_op_type in_optype,
  input  logic [6:0]         in_opcode,
  input  logic [2:0]         in_funct3,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [XLEN-1:0]    in_rs2,
  input  logic [XLEN-1:0]    in_imm,
  input  logic               in_pred_taken,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_taken,
  output logic [XLEN-1:0]    out_target,
  output logic               out_redirect,
  output logic [XLEN-1:0]    out_redirect_pc,
  output logic               out_illegal,
  input  logic [XLEN-1:0]    lk_pc,
  output logic               lk_taken
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic             s1_valid_q, s1_valid_d;
  br_kind_e         s1_kind_q;
  logic [2:0]       s1_funct3_q;
  logic             s1_pred_q, s1_eq_q, s1_lt_q, s1_ltu_q;
  logic [XLEN-1:0]  s1_pc4_q, s1_pcimm_q, s1_jalr_q;
  logic [IDX_W-1:0] s1_idx_q;

  logic             s2_valid_q, s2_valid_d;
  logic             s2_taken_q, s2_taken_d;
  logic [XLEN-1:0]  s2_target_q, s2_target_d;
  logic             s2_redirect_q, s2_redirect_d;
  logic [XLEN-1:0]  s2_rpc_q, s2_rpc_d;
  logic             s2_illegal_q, s2_illegal_d;
  logic             s2_train_q, s2_train_d;
  logic [IDX_W-1:0] s2_idx_q;

  logic     s2_free, accept, s2_load;
  bht_ctr_t lk_ctr;
  logic     lk_pc_unused;

  assign s2_free  = !s2_valid_q || out_ready;
  assign in_ready = !flush && !(s1_valid_q && s2_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign s2_load  = !flush && s2_free && s1_valid_q;

  assign s1_valid_d = flush ? 1'b0 : accept ? 1'b1 : s2_free ? 1'b0 : s1_valid_q;
  assign s2_valid_d = flush ? 1'b0 : s2_free ? s1_valid_q : s2_valid_q;

  always_comb begin
    s2_taken_d   = 1'b0;
    s2_illegal_d = 1'b0;
    unique case (s1_kind_q)
      K_BRANCH: begin
        case (s1_funct3_q)
          F3_BEQ:  s2_taken_d = s1_eq_q;
          F3_BNE:  s2_taken_d = !s1_eq_q;
          F3_BLT:  s2_taken_d = s1_lt_q;
          F3_BGE:  s2_taken_d = !s1_lt_q;
          F3_BLTU: s2_taken_d = s1_ltu_q;
          F3_BGEU: s2_taken_d = !s1_ltu_q;
          default: s2_illegal_d = 1'b1;
        endcase
      end
      K_JAL, K_JALR: s2_taken_d = 1'b1;
      default: s2_taken_d = 1'b0;
    endcase
    s2_target_d   = (s1_kind_q == K_JALR) ? s1_jalr_q : s1_pcimm_q;
    s2_redirect_d = s2_taken_d != s1_pred_q;
    s2_rpc_d      = s2_taken_d ? s2_target_d : s1_pc4_q;
    s2_train_d    = (s1_kind_q == K_BRANCH) && !s2_illegal_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_kind_q     <= K_NONE;
      s1_funct3_q   <= '0;
      s1_pred_q     <= 1'b0;
      s1_eq_q       <= 1'b0;
      s1_lt_q       <= 1'b0;
      s1_ltu_q      <= 1'b0;
      s1_pc4_q      <= '0;
      s1_pcimm_q    <= '0;
      s1_jalr_q     <= '0;
      s1_idx_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_taken_q    <= 1'b0;
      s2_target_q   <= '0;
      s2_redirect_q <= 1'b0;
      s2_rpc_q      <= '0;
      s2_illegal_q  <= 1'b0;
      s2_train_q    <= 1'b0;
      s2_idx_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (accept) begin
        s1_kind_q   <= decode_kind(in_optype, in_opcode);
        s1_funct3_q <= in_funct3;
        s1_pred_q   <= in_pred_taken;
        s1_eq_q     <= in_rs1 == in_rs2;
        s1_lt_q     <= $signed(in_rs1) < $signed(in_rs2);
        s1_ltu_q    <= in_rs1 < in_rs2;
        s1_pc4_q    <= in_pc + XLEN'(4);
        s1_pcimm_q  <= in_pc + in_imm;
        s1_jalr_q   <= (in_rs1 + in_imm) & ~XLEN'(1);
        s1_idx_q    <= in_pc[IDX_W+1:2];
      end
      // Outcome fields only change on a load, so a stalled result stays put.
      if (s2_load) begin
        s2_taken_q    <= s2_taken_d;
        s2_target_q   <= s2_target_d;
        s2_redirect_q <= s2_redirect_d;
        s2_rpc_q      <= s2_rpc_d;
        s2_illegal_q  <= s2_illegal_d;
        s2_train_q    <= s2_train_d;
        s2_idx_q      <= s1_idx_q;
      end
    end
  end

  assign out_valid       = s2_valid_q;
  assign out_taken       = s2_taken_q;
  assign out_target      = s2_target_q;
  assign out_redirect    = s2_redirect_q;
  assign out_redirect_pc = s2_rpc_q;
  assign out_illegal     = s2_illegal_q;

  // A delivery coincident with flush still trains; the flush only drops the entry.
  branch_history_table #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (lk_pc[IDX_W+1:2]),
    .rd_ctr_o    (lk_ctr),
    .upd_en_i    (s2_valid_q && out_ready && s2_train_q),
    .upd_idx_i   (s2_idx_q),
    .upd_taken_i (s2_taken_q)
  );

  assign lk_taken     = lk_ctr[1];
  assign lk_pc_unused = ^{lk_pc[XLEN-1:IDX_W+2], lk_pc[1:0]};

endmodule
